// File: rtl/mips_cpu_data_bridge_if.sv
// CPU data-port and wait-stated memory-bus bundles used by mips_cpu_data_bridge.
// master = side issuing requests, slave = side answering them.
interface mips_cpu_data_bridge_cpu_if;
  logic [31:0] cpu_address;
  logic        cpu_read;
  logic        cpu_write;
  logic [31:0] cpu_writedata;
  logic [3:0]  cpu_byteenable;
  logic [31:0] cpu_readdata;
  logic        cpu_stall;

  modport master (
    output cpu_address, cpu_read, cpu_write, cpu_writedata, cpu_byteenable,
    input  cpu_readdata, cpu_stall
  );
  modport slave (
    input  cpu_address, cpu_read, cpu_write, cpu_writedata, cpu_byteenable,
    output cpu_readdata, cpu_stall
  );
endinterface

interface mips_cpu_data_bridge_bus_if;
  logic [31:0] bus_address;
  logic        bus_read;
  logic        bus_write;
  logic [31:0] bus_writedata;
  logic [3:0]  bus_byteenable;
  logic        bus_waitrequest;
  logic [31:0] bus_readdata;

  modport master (
    output bus_address, bus_read, bus_write, bus_writedata, bus_byteenable,
    input  bus_waitrequest, bus_readdata
  );
  modport slave (
    input  bus_address, bus_read, bus_write, bus_writedata, bus_byteenable,
    output bus_waitrequest, bus_readdata
  );
endinterface

// File: rtl/mips_cpu_data_bridge.sv
// Registers a CPU data access and runs it on a waitrequest bus, stalling the CPU
// until done; zero-wait access takes 3 cycles, each wait state adds one.
module mips_cpu_data_bridge #(
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic                              clk,
  input  logic                              reset,
  mips_cpu_data_bridge_cpu_if.slave         cpu,
  mips_cpu_data_bridge_bus_if.master        bus,
  output logic                              err_timeout,
  output logic                              err_conflict
);

  localparam int          CW       = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    be_q, be_d;
  logic          is_wr_q, is_wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_to_q, err_to_d;
  logic          err_cf_q, err_cf_d;
  logic          req;

  assign req = cpu.cpu_read ^ cpu.cpu_write;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    is_wr_d  = is_wr_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    err_to_d = err_to_q;
    err_cf_d = err_cf_q;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          addr_d  = {cpu.cpu_address[31:2], 2'b00};
          wdata_d = cpu.cpu_writedata;
          be_d    = cpu.cpu_byteenable;
          is_wr_d = cpu.cpu_write;
          cnt_d   = '0;
          state_d = ST_BUSY;
        end else if (cpu.cpu_read && cpu.cpu_write) begin
          err_cf_d = 1'b1;
        end
      end
      ST_BUSY: begin
        if (!bus.bus_waitrequest) begin
          if (!is_wr_q) rdata_d = bus.bus_readdata;
          state_d = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          // Slave never answered: give the CPU a recognisable poison value.
          err_to_d = 1'b1;
          if (!is_wr_q) rdata_d = ERR_DATA;
          state_d = ST_DONE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      is_wr_q  <= 1'b0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      err_to_q <= 1'b0;
      err_cf_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      is_wr_q  <= is_wr_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      err_to_q <= err_to_d;
      err_cf_q <= err_cf_d;
    end
  end

  // Strobes decode straight from state so an async reset drops them at once.
  assign bus.bus_read       = (state_q == ST_BUSY) && !is_wr_q;
  assign bus.bus_write      = (state_q == ST_BUSY) &&  is_wr_q;
  assign bus.bus_address    = addr_q;
  assign bus.bus_writedata  = wdata_q;
  assign bus.bus_byteenable = be_q;

  assign cpu.cpu_stall    = ((state_q == ST_IDLE) && req) || (state_q == ST_BUSY);
  assign cpu.cpu_readdata = rdata_q;

  assign err_timeout  = err_to_q;
  assign err_conflict = err_cf_q;

endmodule

// File: tb/tb_mips_cpu_data_bridge.sv
// Drives CPU requests and a wait-stated bus responder; checks against a per-transaction
// model of stall length, bus cycles, returned data and sticky error flags.
module tb_mips_cpu_data_bridge;

  localparam int          TO  = 4;
  localparam logic [31:0] ERR = 32'hDEADBEEF;

  logic clk = 1'b0;
  logic reset;
  logic err_timeout, err_conflict;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  mips_cpu_data_bridge_cpu_if cif ();
  mips_cpu_data_bridge_bus_if bif ();

  mips_cpu_data_bridge #(.TIMEOUT(TO), .ERR_DATA(ERR)) dut (
    .clk          (clk),
    .reset        (reset),
    .cpu          (cif.slave),
    .bus          (bif.master),
    .err_timeout  (err_timeout),
    .err_conflict (err_conflict)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] m_rdata  = '0;
  logic        m_to     = 1'b0;
  logic        m_cf     = 1'b0;
  bit          in_done  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle_cpu();
    cif.cpu_read  = 1'b0;
    cif.cpu_write = 1'b0;
    if (in_done) @(negedge clk);
    in_done = 1'b0;
  endtask

  // Issue one access; bus holds waitrequest for the first w BUSY cycles.
  // Returns positioned in the DONE cycle (negedge + 1).
  task automatic access(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, input int w, input logic [31:0] rd);
    int  stall_n = 0;
    int  busy_n  = 0;
    bit  aborted;
    int  exp_stall;
    cif.cpu_address    = addr;
    cif.cpu_read       = !wr;
    cif.cpu_write      = wr;
    cif.cpu_writedata  = wd;
    cif.cpu_byteenable = be;
    bif.bus_readdata   = rd;
    bif.bus_waitrequest = 1'b1;
    if (in_done) @(negedge clk);
    in_done = 1'b0;
    for (int c = 0; c < 200; c++) begin
      #1;
      if (!cif.cpu_stall) break;
      stall_n++;
      if (bif.bus_read || bif.bus_write) begin
        busy_n++;
        chk("strobe_kind", {30'b0, bif.bus_read, bif.bus_write}, {30'b0, !wr, wr});
        chk("bus_address", bif.bus_address, {addr[31:2], 2'b00});
        chk("bus_byteenable", {28'b0, bif.bus_byteenable}, {28'b0, be});
        if (wr) chk("bus_writedata", bif.bus_writedata, wd);
        bif.bus_waitrequest = (busy_n <= w);
      end
      @(negedge clk);
    end
    aborted   = (w >= TO);
    exp_stall = aborted ? (1 + TO) : (2 + w);
    if (!wr) m_rdata = aborted ? ERR : rd;
    if (aborted) m_to = 1'b1;
    chk("stall_released", {31'b0, cif.cpu_stall}, 32'd0);
    chk("stall_cycles", stall_n, exp_stall);
    chk("busy_cycles", busy_n, exp_stall - 1);
    chk("done_strobes", {30'b0, bif.bus_read, bif.bus_write}, 32'd0);
    chk("cpu_readdata", cif.cpu_readdata, m_rdata);
    chk("err_timeout", {31'b0, err_timeout}, {31'b0, m_to});
    chk("err_conflict", {31'b0, err_conflict}, {31'b0, m_cf});
    in_done = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_stall"}, {31'b0, cif.cpu_stall}, 32'd0);
    chk({tag, "_strobes"}, {30'b0, bif.bus_read, bif.bus_write}, 32'd0);
    chk({tag, "_address"}, bif.bus_address, 32'd0);
    chk({tag, "_wdata"}, bif.bus_writedata, 32'd0);
    chk({tag, "_be"}, {28'b0, bif.bus_byteenable}, 32'd0);
    chk({tag, "_rdata"}, cif.cpu_readdata, 32'd0);
    chk({tag, "_errs"}, {30'b0, err_timeout, err_conflict}, 32'd0);
  endtask

  initial begin
    int c0;
    reset = 1'b0;
    cif.cpu_address = '0; cif.cpu_read = 1'b0; cif.cpu_write = 1'b0;
    cif.cpu_writedata = '0; cif.cpu_byteenable = '0;
    bif.bus_waitrequest = 1'b0; bif.bus_readdata = '0;
    repeat (3) @(negedge clk);
    #1 check_all_zero("reset");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Aligned-down read, zero wait.
    access(1'b0, 32'h0000_1006, 32'h0, 4'b1111, 0, 32'hCAFE_F00D);
    // Store with three wait states; read data must be untouched.
    access(1'b1, 32'h0000_2000, 32'h1234_5678, 4'b0011, 3, 32'h5555_5555);
    // Stuck slave -> abort, then sticky flag survives good accesses.
    access(1'b0, 32'h0000_3000, 32'h0, 4'b1111, 50, 32'h1111_1111);
    access(1'b0, 32'h0000_3004, 32'h0, 4'b1111, 1, 32'h2222_2222);
    access(1'b1, 32'h0000_3008, 32'hA5A5_A5A5, 4'b1000, 0, 32'h0);

    // Conflicting read+write: no transaction, flag set.
    idle_cpu();
    cif.cpu_read = 1'b1; cif.cpu_write = 1'b1;
    #1;
    chk("conflict_stall", {31'b0, cif.cpu_stall}, 32'd0);
    chk("conflict_strobes", {30'b0, bif.bus_read, bif.bus_write}, 32'd0);
    @(negedge clk); #1;
    m_cf = 1'b1;
    chk("conflict_flag", {31'b0, err_conflict}, 32'd1);
    chk("conflict_idle", {30'b0, bif.bus_read, bif.bus_write}, 32'd0);
    cif.cpu_read = 1'b0; cif.cpu_write = 1'b0;
    @(negedge clk);

    // Back-to-back zero-wait reads: 6 cycles overall.
    c0 = cyc;
    access(1'b0, 32'h0000_0000, 32'h0, 4'b1111, 0, 32'h0BAD_0001);
    access(1'b0, 32'h0000_0004, 32'h0, 4'b1111, 0, 32'h0BAD_0002);
    chk("b2b_cycles", cyc - c0 + 1, 6);

    // Randomised mix including timeouts and idle gaps.
    for (int i = 0; i < 40; i++) begin
      access(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)),
             int'($urandom_range(0, TO + 2)), $urandom);
      if ($urandom_range(0, 3) == 0) begin
        idle_cpu();
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end

    // Async reset during a stalled read.
    idle_cpu();
    cif.cpu_address = 32'h0000_4000; cif.cpu_read = 1'b1;
    bif.bus_waitrequest = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    chk("pre_reset_read", {31'b0, bif.bus_read}, 32'd1);
    reset = 1'b0;
    cif.cpu_read = 1'b0;
    #1;
    chk("reset_drops_read", {31'b0, bif.bus_read}, 32'd0);
    @(negedge clk); @(negedge clk); #1;
    check_all_zero("midreset");
    m_rdata = '0; m_to = 1'b0; m_cf = 1'b0;
    reset = 1'b1;
    @(negedge clk); #1;
    check_all_zero("postreset");
    @(negedge clk);
    access(1'b0, 32'h0000_4002, 32'h0, 4'b1111, 2, 32'h7777_8888);
    idle_cpu();
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
